// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyzer capture engine writing qualified samples into a circular buffer.
// Build option `LA_TRIG_COUNT_EN adds trig_count: the trigger fires on the (trig_count+1)-th match.
//
// state     | meaning
// S_IDLE    | waiting for arm, no writes
// S_PRETRIG | filling the pre-trigger window, trigger ignored
// S_ARMED   | writing samples and watching for the trigger
// S_CAPTURE | writing post-trigger samples until the buffer closes
// S_DONE    | capture frozen, buffer readable in chronological order
module la_capture_core #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_BITS  = 9,
   parameter int DIN_REG    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  sample_en,
   input  logic                  arm,
   input  logic [ADDR_BITS-1:0]  pretrig_len,
   input  logic [DATA_WIDTH-1:0] trigger_low,
   input  logic [DATA_WIDTH-1:0] trigger_high,
   input  logic [DATA_WIDTH-1:0] trigger_rising,
   input  logic [DATA_WIDTH-1:0] trigger_falling,
`ifdef LA_TRIG_COUNT_EN
   input  logic [7:0]            trig_count,
`endif
   input  logic [ADDR_BITS-1:0]  read_addr,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic [ADDR_BITS-1:0]  trig_pos,
   output logic                  armed,
   output logic                  done
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRETRIG,
      S_ARMED,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t state, state_n;

   logic [DATA_WIDTH-1:0] smp_data;
   logic                  smp_en;
   logic [DATA_WIDTH-1:0] prev;
   logic                  prev_valid;
   logic [ADDR_BITS-1:0]  waddr, pre_left, p_len, start_addr, end_addr, last_addr, rd_idx;
   logic                  rise_ok, fall_ok, match, count_ok;
   logic                  mem_we, arm_go, trig_fire;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   generate
      if (DIN_REG != 0) begin : g_din_reg
         logic [DATA_WIDTH-1:0] din_q;
         logic                  sample_en_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               din_q       <= '0;
               sample_en_q <= 1'b0;
            end else begin
               din_q       <= din;
               sample_en_q <= sample_en;
            end
         end
         assign smp_data = din_q;
         assign smp_en   = sample_en_q;
      end else begin : g_din_direct
         assign smp_data = din;
         assign smp_en   = sample_en;
      end
   endgenerate

   // Edge terms need a valid previous sample; an unused (all-zero) mask always passes.
   always_comb begin
      rise_ok = 1'b1;
      fall_ok = 1'b1;
      if (trigger_rising != '0)
         rise_ok = prev_valid && ((smp_data & ~prev & trigger_rising) == trigger_rising);
      if (trigger_falling != '0)
         fall_ok = prev_valid && ((~smp_data & prev & trigger_falling) == trigger_falling);
      match = ((smp_data & trigger_high) == trigger_high)
           && ((~smp_data & trigger_low) == trigger_low)
           && rise_ok && fall_ok;
   end

`ifdef LA_TRIG_COUNT_EN
   logic [7:0] match_left;
   assign count_ok = (match_left == 8'd0);
`else
   assign count_ok = 1'b1;
`endif

   // End address if the current sample were the trigger; equal to waddr only when P = D-1.
   assign last_addr = waddr - p_len - 1'b1;
   assign rd_idx    = read_addr + start_addr;

   always_comb begin
      state_n   = state;
      mem_we    = 1'b0;
      arm_go    = 1'b0;
      trig_fire = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (arm) begin
               arm_go  = 1'b1;
               state_n = (pretrig_len == '0) ? S_ARMED : S_PRETRIG;
            end
         end
         S_PRETRIG: begin
            if (smp_en) begin
               mem_we = 1'b1;
               if (pre_left == ADDR_BITS'(1)) state_n = S_ARMED;
            end
         end
         S_ARMED: begin
            if (smp_en) begin
               mem_we = 1'b1;
               if (match && count_ok) begin
                  trig_fire = 1'b1;
                  state_n   = (waddr == last_addr) ? S_DONE : S_CAPTURE;
               end
            end
         end
         S_CAPTURE: begin
            if (smp_en) begin
               mem_we = 1'b1;
               if (waddr == end_addr) state_n = S_DONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // pretrig_len is ADDR_BITS wide, so it can never exceed D-1 and needs no clamp.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         waddr      <= '0;
         pre_left   <= '0;
         p_len      <= '0;
         start_addr <= '0;
         end_addr   <= '0;
         trig_pos   <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
         match_left <= 8'd0;
`endif
      end else begin
         state <= state_n;
         if (arm_go) begin
            waddr      <= '0;
            pre_left   <= pretrig_len;
            p_len      <= pretrig_len;
            prev_valid <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
            match_left <= trig_count;
`endif
         end else begin
            if (mem_we) waddr <= waddr + 1'b1;
            if (state == S_PRETRIG && smp_en) pre_left <= pre_left - 1'b1;
            if (smp_en) begin
               prev       <= smp_data;
               prev_valid <= 1'b1;
            end
`ifdef LA_TRIG_COUNT_EN
            if (state == S_ARMED && smp_en && match && !count_ok)
               match_left <= match_left - 8'd1;
`endif
         end
         if (trig_fire) begin
            start_addr <= waddr - p_len;
            end_addr   <= last_addr;
            trig_pos   <= p_len;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[waddr] <= smp_data;
   end

   always_ff @(posedge clk) begin
      if (reset)
         read_data <= '0;
      else if (state == S_DONE)
         read_data <= mem[rd_idx];
   end

   assign armed = (state == S_PRETRIG) || (state == S_ARMED);
   assign done  = (state == S_DONE);

endmodule
